// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundles the control-side inputs and the PC-side outputs
// of the program counter sequencer. The slave modport is the sequencer; the
// master modport is whatever drives it (pipeline control or a testbench).
interface pc_sequencer_if;
    logic [31:0] curr_addr;
    logic        imem_ready;
    logic        dmem_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        exc;
    logic        halt_in;
    logic        resume;
    logic [31:0] next_addr;
    logic        stall_pc;
    logic        halt_pc;
    logic        imem_req;
    logic        flush;
    logic        timeout_err;
    logic [2:0]  state;
    logic [31:0] stall_cycles;

    modport master (
        output curr_addr, imem_ready, dmem_stall, branch_taken, branch_target,
               exc, halt_in, resume,
        input  next_addr, stall_pc, halt_pc, imem_req, flush, timeout_err,
               state, stall_cycles
    );

    modport slave (
        input  curr_addr, imem_ready, dmem_stall, branch_taken, branch_target,
               exc, halt_in, resume,
        output next_addr, stall_pc, halt_pc, imem_req, flush, timeout_err,
               state, stall_cycles
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: decides the next fetch address each cycle and whether the PC
// writes, stalls or halts. Redirects arriving while the PC is stalled are held
// in a one-entry pending slot and applied on the next PC write.
// Optional build macro PC_SEQ_PERF_CNT_EN enables the saturating stall-cycle
// counter on stall_cycles; without it stall_cycles is tied to zero.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR     = 32'h0000_0100,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input logic            clk,
    input logic            rst,
    pc_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        BOOT      = 3'd0,
        RUN       = 3'd1,
        WAIT_IMEM = 3'd2,
        HALTED    = 3'd3,
        ERR       = 3'd4
    } state_t;

    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        pend_valid_q, pend_valid_d;
    logic        pend_exc_q, pend_exc_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [31:0] next_addr_o;
    logic        stall_pc_o;
    logic        halt_pc_o;
    logic        imem_req_o;
    logic        flush_o;
    logic        timeout_err_o;
    logic        stalled;
    logic [8:0]  cnt_inc;
    logic [31:0] seq_addr;
    logic [31:0] br_addr;

    // State, pending redirect slot and imem wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            pend_valid_q <= 1'b0;
            pend_exc_q   <= 1'b0;
            pend_addr_q  <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_exc_q   <= pend_exc_d;
            pend_addr_q  <= pend_addr_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state, redirect arbitration and PC control outputs.
    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_exc_d    = pend_exc_q;
        pend_addr_d   = pend_addr_q;
        cnt_d         = cnt_q;
        next_addr_o   = bus.curr_addr;
        stall_pc_o    = 1'b0;
        halt_pc_o     = 1'b0;
        imem_req_o    = 1'b0;
        flush_o       = 1'b0;
        timeout_err_o = 1'b0;
        stalled       = 1'b0;
        cnt_inc       = {1'b0, cnt_q} + 9'd1;
        seq_addr      = bus.curr_addr + 32'd4;
        br_addr       = bus.branch_target & ~32'd3;

        unique case (state_q)
            BOOT: begin
                next_addr_o = RESET_VECTOR;
                state_d     = RUN;
            end
            RUN, WAIT_IMEM: begin
                imem_req_o = 1'b1;
                if (!bus.imem_ready) begin
                    if (state_q == RUN) begin
                        cnt_d   = 8'd1;
                        state_d = WAIT_IMEM;
                    end else begin
                        cnt_d   = cnt_inc[7:0];
                        state_d = (cnt_inc >= TIMEOUT_LIM) ? ERR : WAIT_IMEM;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
                stalled = bus.dmem_stall || !bus.imem_ready;
                if (stalled) begin
                    // PC frozen: capture the redirect; an exception may replace
                    // a held branch but a branch never replaces a held exception.
                    stall_pc_o = 1'b1;
                    if (bus.exc) begin
                        pend_valid_d = 1'b1;
                        pend_exc_d   = 1'b1;
                        pend_addr_d  = EXC_VECTOR;
                        flush_o      = 1'b1;
                    end else if (bus.branch_taken && !(pend_valid_q && pend_exc_q)) begin
                        pend_valid_d = 1'b1;
                        pend_exc_d   = 1'b0;
                        pend_addr_d  = br_addr;
                        flush_o      = 1'b1;
                    end
                end else begin
                    pend_valid_d = 1'b0;
                    pend_exc_d   = 1'b0;
                    if (bus.exc) begin
                        next_addr_o = EXC_VECTOR;
                        flush_o     = 1'b1;
                    end else if (pend_valid_q) begin
                        next_addr_o = pend_addr_q;
                    end else if (bus.halt_in) begin
                        halt_pc_o = 1'b1;
                        state_d   = HALTED;
                    end else if (bus.branch_taken) begin
                        next_addr_o = br_addr;
                        flush_o     = 1'b1;
                    end else begin
                        next_addr_o = seq_addr;
                    end
                end
            end
            HALTED: begin
                halt_pc_o    = 1'b1;
                pend_valid_d = 1'b0;
                pend_exc_d   = 1'b0;
                if (bus.resume) begin
                    halt_pc_o   = 1'b0;
                    next_addr_o = seq_addr;
                    state_d     = RUN;
                end
            end
            ERR: begin
                halt_pc_o     = 1'b1;
                timeout_err_o = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign bus.next_addr   = next_addr_o;
    assign bus.stall_pc    = stall_pc_o;
    assign bus.halt_pc     = halt_pc_o;
    assign bus.imem_req    = imem_req_o;
    assign bus.flush       = flush_o;
    assign bus.timeout_err = timeout_err_o;
    assign bus.state       = state_q;

`ifdef PC_SEQ_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // Saturating count of cycles spent stalled or waiting on imem.
    always_comb begin
        perf_d = perf_q;
        if ((stall_pc_o || state_q == WAIT_IMEM) && perf_q != 32'hFFFF_FFFF)
            perf_d = perf_q + 32'd1;
    end

    // Performance counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign bus.stall_cycles = perf_q;
`else
    assign bus.stall_cycles = 32'd0;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller for the program counter register: each cycle it decides the next fetch address, and whether the PC writes, stalls or halts.
- Arbitrates sequential fetch, branch redirect, exception redirect, halt/resume and instruction-memory wait.
- Holds redirects that arrive while the PC is stalled, so none are lost.
- Sits between decode/execute/memory control and the PC; drives the PC's nextAddr, stallPC and halt inputs.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address loaded after reset
EXC_VECTOR, 32'h0000_0100, exception handler address
TIMEOUT_CYCLES, 255, max consecutive WAIT_IMEM cycles before error (8-bit counter)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
curr_addr  in  32  current PC value
imem_ready  in  1  instruction memory has data for curr_addr
dmem_stall  in  1  data-side stall, hold PC
branch_taken  in  1  redirect request from execute
branch_target  in  32  redirect address
exc  in  1  exception request
halt_in  in  1  halt instruction decoded
resume  in  1  restart from HALTED
next_addr  out  32  to PC nextAddr
stall_pc  out  1  to PC stallPC
halt_pc  out  1  to PC halt
imem_req  out  1  fetch request
flush  out  1  squash younger instructions
timeout_err  out  1  sticky imem timeout flag
state  out  3  FSM state, debug
stall_cycles  out  32  perf counter (see Optional Feature)

Behaviour:
- PC writes on a cycle iff stall_pc=0 and halt_pc=0.
- States: BOOT=0, RUN=1, WAIT_IMEM=2, HALTED=3, ERR=4.
- Reset (async, any time, including mid-wait): state=BOOT, pending redirect cleared, counter=0.
  - Reset outputs: next_addr=RESET_VECTOR, stall_pc=0, halt_pc=0, imem_req=0, flush=0, timeout_err=0.
- BOOT: lasts one cycle; PC loads RESET_VECTOR; next state RUN.
- RUN: imem_req=1. next_addr priority, highest first:
  - exc → EXC_VECTOR
  - pending redirect → pend_addr
  - halt_in → no write, go HALTED
  - branch_taken → branch_target
  - otherwise → curr_addr+4
- flush=1 in any cycle where exc or branch_taken is accepted, whether applied or captured.
- RUN stall rules:
  - dmem_stall=1: stall_pc=1, stay RUN, counter untouched.
  - imem_ready=0 (with or without dmem_stall): stall_pc=1, go WAIT_IMEM, counter=1.
- Redirect arriving while stall_pc=1: captured into pend_valid/pend_addr, applied on the next PC write.
  - exc overwrites a pending branch; a branch never overwrites a pending exc.
- WAIT_IMEM: stall_pc=1 and counter increments each cycle, until imem_ready=1.
  - On imem_ready=1: that cycle stall_pc=0 (unless dmem_stall=1), next_addr per RUN priority, counter=0, go RUN.
  - Counter reaching TIMEOUT_CYCLES → ERR.
- HALTED: halt_pc=1, imem_req=0, pending cleared, exc/branch ignored.
  - resume=1: halt_pc=0 that cycle, next_addr=curr_addr+4, go RUN.
- ERR: halt_pc=1, timeout_err=1 sticky; only rst exits.
- Arithmetic: curr_addr+4 wraps modulo 2^32 (0xFFFF_FFFC → 0).
  - branch_target[1:0] forced to 0 before use.

Optional Feature:
PC_SEQ_PERF_CNT_EN:
- Defined: stall_cycles counts cycles with stall_pc=1 or state=WAIT_IMEM; 32-bit, saturates at all-ones, cleared by rst.
- Undefined: stall_cycles tied to 0; no counter logic.

Test Plan:
- Release rst, imem_ready=1 → BOOT 1 cycle, next_addr=0x0, then 0x4, 0x8 on successive cycles, stall_pc=0.
- At curr_addr=0x10, branch_taken=1, target=0x43 → next_addr=0x40, flush=1 for 1 cycle.
- dmem_stall=1 for 3 cycles, branch to 0x80 in 2nd cycle → stall_pc=1 for 3 cycles; on release next_addr=0x80, no counter increment.
- halt_in at 0x20 → halt_pc=1, PC holds 0x20; 5 cycles later resume → next_addr=0x24, state=RUN.
- imem_ready=0 held for 255 cycles → state=ERR, timeout_err=1, halt_pc=1; assert rst mid-ERR → all reset values, BOOT.
- curr_addr=0xFFFF_FFFC, no redirect → next_addr=0x0; exc and branch same cycle → next_addr=0x100.
